// File: rtl/sc_ifetch.sv
// sc_ifetch: instruction-fetch / PC-update stage of the single-cycle CPU.
// Fetches from a variable-latency instruction memory (req/ack), then holds the
// instruction for one EXEC window that a downstream stall can stretch.
// Optional build macro: IFETCH_TIMEOUT_EN adds a bounded FETCH wait that
// raises fetch_err and halts if memory never acks.
module sc_ifetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] next_pc;
    logic        misalign;
    logic        to_hit;

    // Elaboration-time sanity on the configuration.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("sc_ifetch: RESET_PC must be word-aligned");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sc_ifetch: TIMEOUT_CYCLES must be at least 1");
    end

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;

    // Next-PC select; only the value present at the EXEC exit edge matters.
    always_comb begin
        next_pc = pc4;
        case (pcsource)
            2'd0: next_pc = pc4;
            2'd1: next_pc = bpc;
            2'd2: next_pc = da;
            2'd3: next_pc = jpc;
            default: next_pc = pc4;
        endcase
    end

    assign misalign = (next_pc[1:0] != 2'b00);

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] to_cnt_q;

    // Counts FETCH cycles without ack; outside FETCH it sits at zero so every
    // fetch starts from a cleared count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                to_cnt_q <= '0;
        else if (state_q == S_FETCH) to_cnt_q <= to_cnt_q + 1'b1;
        else                        to_cnt_q <= '0;
    end

    // Limit is hit in the FETCH cycle that would make the count reach
    // TIMEOUT_CYCLES; a same-cycle ack takes priority over the error.
    assign to_hit = (state_q == S_FETCH) && !imem_ack &&
                    ((32'(to_cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));
`else
    assign to_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and handshake outputs; req and inst_valid are mutually exclusive.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)    state_d = S_EXEC;
                else if (to_hit) state_d = S_HALT;
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (!stall) state_d = misalign ? S_HALT : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // PC, instruction latch and sticky error; all frozen once halted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc        <= RESET_PC;
            inst      <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack)    inst      <= imem_rdata;
                    else if (to_hit) fetch_err <= 1'b1;
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (misalign) fetch_err <= 1'b1;
                        else          pc        <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
